// File: rtl/gb_oam_scan.sv
// -----------------------------------------------------------------------------
// gb_oam_scan -- PPU Mode 2 OAM search engine (reader side of OAM/DMA block)
//
// Walks all NUM_OBJECTS OAM entries (2 dots each: FETCH then EVAL), compares
// each object's Y against the scanline latched at scan_start and stores up to
// MAX_SPRITES matching objects, in OAM order, into a line sprite buffer that
// the Mode 3 pixel fetcher reads combinationally.
//
// Ports:
//   clk              PPU dot clock, rising edge
//   reset            asynchronous active-low reset
//   scan_start       one-dot pulse starting (or restarting) the line scan
//   ly_i             current scanline, latched at scan_start
//   obj_tall_i       LCDC.2 (1 = 8x16 objects), latched at scan_start
//   dma_active_i     OAM DMA in progress
//   index_ppu_o      object index driven to OAM
//   obj_i            object returned by OAM for index_ppu_o (combinational)
//   scan_active_o    high during FETCH/EVAL (80 dots)
//   scan_done_o      one-dot pulse in DONE
//   sprite_count_o   number of objects latched (0..MAX_SPRITES)
//   buf_index_i      sprite buffer read select
//   buf_obj_o        buffer entry at buf_index_i (0 when invalid)
//   buf_oam_index_o  OAM index of that entry (0 when invalid)
//   buf_valid_o      buf_index_i < sprite_count_o
//
// Build option:
//   OAM_SCAN_DMA_BLOCK_EN -- when defined, an object whose EVAL dot sees
//   dma_active_i = 1 is forced non-matching. When undefined, dma_active_i is
//   ignored.
// -----------------------------------------------------------------------------
package gb_oam_pkg;
  typedef struct packed {
    logic [7:0] y_position;
    logic [7:0] x_position;
    logic [7:0] tile_index;
    logic [7:0] attributes;
  } oam_obj_t;
endpackage

module gb_oam_scan
  import gb_oam_pkg::*;
#(
  parameter int NUM_OBJECTS = 40,
  parameter int MAX_SPRITES = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scan_start,
  input  logic [7:0] ly_i,
  input  logic       obj_tall_i,
  input  logic       dma_active_i,
  output logic [6:0] index_ppu_o,
  input  oam_obj_t   obj_i,
  output logic       scan_active_o,
  output logic       scan_done_o,
  output logic [3:0] sprite_count_o,
  input  logic [3:0] buf_index_i,
  output oam_obj_t   buf_obj_o,
  output logic [5:0] buf_oam_index_o,
  output logic       buf_valid_o
);

  localparam logic [5:0] LAST_OBJ = 6'(NUM_OBJECTS - 1);
  localparam logic [3:0] MAX_CNT  = 4'(MAX_SPRITES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EVAL  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] counter_q, counter_d;
  logic [3:0] count_q, count_d;
  logic       tall_q, tall_d;
  logic [7:0] line_q, line_d;
  oam_obj_t   buf_obj_q [MAX_SPRITES];
  oam_obj_t   buf_obj_d [MAX_SPRITES];
  logic [5:0] buf_idx_q [MAX_SPRITES];
  logic [5:0] buf_idx_d [MAX_SPRITES];

  logic       dma_block_s;
  logic [8:0] diff_s;
  logic [8:0] height_s;
  logic       match_s;
  logic       store_s;
  logic       rd_valid_s;
  oam_obj_t   rd_obj_s;
  logic [5:0] rd_idx_s;

`ifdef OAM_SCAN_DMA_BLOCK_EN
  assign dma_block_s = dma_active_i;
`else
  assign dma_block_s = dma_active_i & 1'b0;
`endif

  // Y match: 9-bit wrapping distance from the object's top row (Y is offset
  // by 16) to the latched line. Y = 0 or Y >= 160 can never land below height.
  always_comb begin
    diff_s   = {1'b0, line_q} + 9'd16 - {1'b0, obj_i.y_position};
    height_s = tall_q ? 9'd16 : 9'd8;
    match_s  = (diff_s < height_s) && !dma_block_s;
    store_s  = (state_q == ST_EVAL) && match_s && (count_q < MAX_CNT);
  end

  // Next-state and buffer-write logic; scan_start overrides everything so a
  // mid-scan pulse restarts cleanly.
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    count_d   = count_q;
    tall_d    = tall_q;
    line_d    = line_q;
    for (int i = 0; i < MAX_SPRITES; i++) begin
      if (store_s && (count_q == 4'(i))) begin
        buf_obj_d[i] = obj_i;
        buf_idx_d[i] = counter_q;
      end else begin
        buf_obj_d[i] = buf_obj_q[i];
        buf_idx_d[i] = buf_idx_q[i];
      end
    end

    if (scan_start) begin
      state_d   = ST_FETCH;
      counter_d = 6'd0;
      count_d   = 4'd0;
      tall_d    = obj_tall_i;
      line_d    = ly_i;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_FETCH: begin
          state_d = ST_EVAL;
        end
        ST_EVAL: begin
          if (store_s) begin
            count_d = count_q + 4'd1;
          end else begin
            count_d = count_q;
          end
          if (counter_q == LAST_OBJ) begin
            state_d   = ST_DONE;
            counter_d = 6'd0;
          end else begin
            state_d   = ST_FETCH;
            counter_d = counter_q + 6'd1;
          end
        end
        ST_DONE: begin
          state_d   = ST_IDLE;
          counter_d = 6'd0;
        end
        default: begin
          state_d   = ST_IDLE;
          counter_d = 6'd0;
        end
      endcase
    end
  end

  // State, scan context and sprite buffer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      counter_q <= 6'd0;
      count_q   <= 4'd0;
      tall_q    <= 1'b0;
      line_q    <= 8'd0;
      for (int i = 0; i < MAX_SPRITES; i++) begin
        buf_obj_q[i] <= '0;
        buf_idx_q[i] <= 6'd0;
      end
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      count_q   <= count_d;
      tall_q    <= tall_d;
      line_q    <= line_d;
      for (int i = 0; i < MAX_SPRITES; i++) begin
        buf_obj_q[i] <= buf_obj_d[i];
        buf_idx_q[i] <= buf_idx_d[i];
      end
    end
  end

  // Buffer read mux: entries at or beyond the live count read as zero.
  always_comb begin
    rd_valid_s = (buf_index_i < count_q);
    rd_obj_s   = '0;
    rd_idx_s   = 6'd0;
    for (int i = 0; i < MAX_SPRITES; i++) begin
      rd_obj_s = rd_obj_s |
                 ((rd_valid_s && (buf_index_i == 4'(i))) ? buf_obj_q[i] : '0);
      rd_idx_s = rd_idx_s |
                 ((rd_valid_s && (buf_index_i == 4'(i))) ? buf_idx_q[i] : 6'd0);
    end
  end

  assign index_ppu_o     = {1'b0, counter_q};
  assign scan_active_o   = (state_q == ST_FETCH) || (state_q == ST_EVAL);
  assign scan_done_o     = (state_q == ST_DONE);
  assign sprite_count_o  = count_q;
  assign buf_valid_o     = rd_valid_s;
  assign buf_obj_o       = rd_obj_s;
  assign buf_oam_index_o = rd_idx_s;

endmodule
